// File: rtl/frame_header_gen.sv
// Streams a complete ProRes frame header into the bit packer as (val, size_of_bit)
// beats: 23 fixed fields, then the optional luma and chroma quantisation matrices.
// One header is produced per accepted start. The beat stream honours out_ready, and
// flush_bit marks the last beat.
//
// Ports
//   clock, reset_n              clock, asynchronous active-low reset
//   start                       request one header (accepted in IDLE only)
//   frame_size .. alpha_*       header field values, captured when start is accepted
//   load_luma/chroma_qmat       include the luma / chroma matrix
//   y_qmat, c_qmat              matrices, entry k at bits [8k+7:8k]
//   out_ready                   downstream accepts the current beat
//   output_enable               beat valid
//   val, size_of_bit            field value (right-justified) and field length in bits
//   flush_bit                   final beat of the header
//   busy, done                  header in progress / one-cycle completion pulse
module frame_header_gen #(
    parameter int unsigned VAL_W         = 64,
    parameter int unsigned QMAT_PER_BEAT = 1,
    parameter logic [31:0] ENCODER_ID    = 32'h4c617663
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [31:0]      frame_size,
    input  logic [15:0]      horizontal,
    input  logic [15:0]      vertical,
    input  logic [1:0]       chroma_format,
    input  logic [1:0]       interlace_mode,
    input  logic [3:0]       aspect_ratio_information,
    input  logic [3:0]       frame_rate_code,
    input  logic [7:0]       color_primaries,
    input  logic [7:0]       transfer_characteristic,
    input  logic [7:0]       matrix_coefficients,
    input  logic [3:0]       alpha_channel_type,
    input  logic             load_luma_qmat,
    input  logic             load_chroma_qmat,
    input  logic [511:0]     y_qmat,
    input  logic [511:0]     c_qmat,
    input  logic             out_ready,
    output logic             output_enable,
    output logic [VAL_W-1:0] val,
    output logic [VAL_W-1:0] size_of_bit,
    output logic             flush_bit,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W     = 6;
    localparam int unsigned FIELD_CNT = 23;
    localparam int unsigned MAT_BEATS = 64 / QMAT_PER_BEAT;
    localparam logic [IDX_W-1:0] LAST_FIELD = IDX_W'(FIELD_CNT - 1);
    localparam logic [IDX_W-1:0] LAST_MAT   = IDX_W'(MAT_BEATS - 1);

    typedef enum logic [2:0] {IDLE, FIELDS, LUMA, CHROMA, DONE} state_t;

    typedef struct packed {
        logic [31:0]  frame_size;
        logic [15:0]  horizontal;
        logic [15:0]  vertical;
        logic [1:0]   chroma_format;
        logic [1:0]   interlace_mode;
        logic [3:0]   aspect;
        logic [3:0]   frame_rate;
        logic [7:0]   primaries;
        logic [7:0]   transfer;
        logic [7:0]   matrix;
        logic [3:0]   alpha;
        logic         load_luma;
        logic         load_chroma;
        logic [511:0] y_qmat;
        logic [511:0] c_qmat;
    } hdr_cfg_t;

    typedef struct packed {
        logic [VAL_W-1:0] val;
        logic [VAL_W-1:0] size;
    } beat_t;

    // Fixed header field i of configuration c.
    function automatic beat_t field_beat(input hdr_cfg_t c, input logic [IDX_W-1:0] i);
        beat_t       b;
        logic [31:0] v;
        logic [5:0]  sz;
        logic [15:0] hdr;
        hdr = 16'd20 + (c.load_luma ? 16'd64 : 16'd0) + (c.load_chroma ? 16'd64 : 16'd0);
        v   = '0;
        sz  = '0;
        case (i)
            6'd0:  begin v = c.frame_size;           sz = 6'd32; end
            6'd1:  begin v = 32'h69637066;           sz = 6'd32; end
            6'd2:  begin v = 32'(hdr);               sz = 6'd16; end
            6'd3:  sz = 6'd8;
            6'd4:  sz = 6'd8;
            6'd5:  begin v = ENCODER_ID;             sz = 6'd32; end
            6'd6:  begin v = 32'(c.horizontal);      sz = 6'd16; end
            6'd7:  begin v = 32'(c.vertical);        sz = 6'd16; end
            6'd8:  begin v = 32'(c.chroma_format);   sz = 6'd2;  end
            6'd9:  sz = 6'd2;
            6'd10: begin v = 32'(c.interlace_mode);  sz = 6'd2;  end
            6'd11: sz = 6'd2;
            6'd12: begin v = 32'(c.aspect);          sz = 6'd4;  end
            6'd13: begin v = 32'(c.frame_rate);      sz = 6'd4;  end
            6'd14: begin v = 32'(c.primaries);       sz = 6'd8;  end
            6'd15: begin v = 32'(c.transfer);        sz = 6'd8;  end
            6'd16: begin v = 32'(c.matrix);          sz = 6'd8;  end
            6'd17: begin v = 32'd4;                  sz = 6'd4;  end
            6'd18: begin v = 32'(c.alpha);           sz = 6'd4;  end
            6'd19: sz = 6'd8;
            6'd20: sz = 6'd6;
            6'd21: begin v = 32'(c.load_luma);       sz = 6'd1;  end
            6'd22: begin v = 32'(c.load_chroma);     sz = 6'd1;  end
            default: ;
        endcase
        b.val  = VAL_W'(v);
        b.size = VAL_W'(sz);
        return b;
    endfunction

    // Matrix beat j: entries j*N .. j*N+N-1, lowest index in the top byte.
    function automatic beat_t mat_beat(input logic [511:0] q, input logic [IDX_W-1:0] j);
        beat_t            b;
        logic [VAL_W-1:0] v;
        logic [8:0]       bit_lo;
        v = '0;
        for (int unsigned m = 0; m < QMAT_PER_BEAT; m++) begin
            bit_lo = 9'(8 * (32'(j) * QMAT_PER_BEAT + m));
            v = (v << 8) | VAL_W'(q[bit_lo +: 8]);
        end
        b.val  = v;
        b.size = VAL_W'(8 * QMAT_PER_BEAT);
        return b;
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
    hdr_cfg_t         cfg_q, cfg_d, cfg_in;
    logic             oe_q, oe_d, flush_q, flush_d, busy_q, busy_d, done_q, done_d;
    logic [VAL_W-1:0] val_q, val_d, size_q, size_d;
    logic             fire, load, finish;
    beat_t            nxt;

    assign cfg_in = '{frame_size: frame_size, horizontal: horizontal, vertical: vertical,
                      chroma_format: chroma_format, interlace_mode: interlace_mode,
                      aspect: aspect_ratio_information, frame_rate: frame_rate_code,
                      primaries: color_primaries, transfer: transfer_characteristic,
                      matrix: matrix_coefficients, alpha: alpha_channel_type,
                      load_luma: load_luma_qmat, load_chroma: load_chroma_qmat,
                      y_qmat: y_qmat, c_qmat: c_qmat};

    // State, shadow configuration and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cfg_q   <= '0;
            oe_q    <= 1'b0;
            val_q   <= '0;
            size_q  <= '0;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cfg_q   <= cfg_d;
            oe_q    <= oe_d;
            val_q   <= val_d;
            size_q  <= size_d;
            flush_q <= flush_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state and next beat; a new beat is loaded only on a transfer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cfg_d   = cfg_q;
        oe_d    = oe_q;
        val_d   = val_q;
        size_d  = size_q;
        flush_d = flush_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        nxt     = '0;
        load    = 1'b0;
        finish  = 1'b0;
        fire    = oe_q && out_ready;
        idx_inc = idx_q + 6'd1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cfg_d   = cfg_in;
                    state_d = FIELDS;
                    idx_d   = '0;
                    nxt     = field_beat(cfg_in, '0);
                    load    = 1'b1;
                    flush_d = 1'b0;
                end
            end
            FIELDS: begin
                if (fire) begin
                    if (idx_q == LAST_FIELD) begin
                        idx_d = '0;
                        if (cfg_q.load_luma) begin
                            state_d = LUMA;
                            nxt     = mat_beat(cfg_q.y_qmat, '0);
                            load    = 1'b1;
                            flush_d = 1'b0;
                        end else if (cfg_q.load_chroma) begin
                            state_d = CHROMA;
                            nxt     = mat_beat(cfg_q.c_qmat, '0);
                            load    = 1'b1;
                            flush_d = 1'b0;
                        end else begin
                            finish = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_inc;
                        nxt     = field_beat(cfg_q, idx_inc);
                        load    = 1'b1;
                        flush_d = (idx_inc == LAST_FIELD) && !cfg_q.load_luma && !cfg_q.load_chroma;
                    end
                end
            end
            LUMA: begin
                if (fire) begin
                    if (idx_q == LAST_MAT) begin
                        idx_d = '0;
                        if (cfg_q.load_chroma) begin
                            state_d = CHROMA;
                            nxt     = mat_beat(cfg_q.c_qmat, '0);
                            load    = 1'b1;
                            flush_d = 1'b0;
                        end else begin
                            finish = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_inc;
                        nxt     = mat_beat(cfg_q.y_qmat, idx_inc);
                        load    = 1'b1;
                        flush_d = (idx_inc == LAST_MAT) && !cfg_q.load_chroma;
                    end
                end
            end
            CHROMA: begin
                if (fire) begin
                    if (idx_q == LAST_MAT) begin
                        idx_d  = '0;
                        finish = 1'b1;
                    end else begin
                        idx_d   = idx_inc;
                        nxt     = mat_beat(cfg_q.c_qmat, idx_inc);
                        load    = 1'b1;
                        flush_d = (idx_inc == LAST_MAT);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            oe_d   = 1'b1;
            busy_d = 1'b1;
            val_d  = nxt.val;
            size_d = nxt.size;
        end
        if (finish) begin
            state_d = DONE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            val_d   = '0;
            size_d  = '0;
            flush_d = 1'b0;
        end
    end

    assign output_enable = oe_q;
    assign val           = val_q;
    assign size_of_bit   = size_q;
    assign flush_bit     = flush_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_frame_header_gen.sv
// Bench for frame_header_gen: two instances (1 and 8 matrix entries per beat) share
// stimulus; transferred beats are compared against a list-based header model.
module tb_frame_header_gen;

    localparam logic [31:0] ENC = 32'h4c617663;
    localparam int FSZ [23] = '{32, 32, 16, 8, 8, 32, 16, 16, 2, 2, 2, 2, 4, 4, 8, 8, 8, 4, 4, 8, 6, 1, 1};

    typedef struct {
        logic [31:0]  frame_size;
        logic [15:0]  h, v;
        logic [1:0]   cf, im;
        logic [3:0]   ar, fr;
        logic [7:0]   cp, tc, mc;
        logic [3:0]   al;
        logic         ll, lc;
        logic [511:0] y, c;
    } cfg_t;

    typedef struct {
        logic [63:0] v;
        logic [63:0] s;
        logic        f;
    } beat_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic [31:0] frame_size = '0;
    logic [15:0] horizontal = '0, vertical = '0;
    logic [1:0] chroma_format = '0, interlace_mode = '0;
    logic [3:0] aspect_ratio_information = '0, frame_rate_code = '0, alpha_channel_type = '0;
    logic [7:0] color_primaries = '0, transfer_characteristic = '0, matrix_coefficients = '0;
    logic load_luma_qmat = 1'b0, load_chroma_qmat = 1'b0;
    logic [511:0] y_qmat = '0, c_qmat = '0;
    logic out_ready = 1'b1;
    bit bp = 1'b0;

    logic oe1, flush1, busy1, done1, oe8, flush8, busy8, done8;
    logic [63:0] val1, size1, val8, size8;

    int total = 0;
    int bad = 0;
    beat_t got1[$], got8[$], exp1[$], exp8[$];

    always #5 clock = ~clock;

    frame_header_gen dut1 (
        .clock(clock), .reset_n(reset_n), .start(start), .frame_size(frame_size),
        .horizontal(horizontal), .vertical(vertical), .chroma_format(chroma_format),
        .interlace_mode(interlace_mode), .aspect_ratio_information(aspect_ratio_information),
        .frame_rate_code(frame_rate_code), .color_primaries(color_primaries),
        .transfer_characteristic(transfer_characteristic), .matrix_coefficients(matrix_coefficients),
        .alpha_channel_type(alpha_channel_type), .load_luma_qmat(load_luma_qmat),
        .load_chroma_qmat(load_chroma_qmat), .y_qmat(y_qmat), .c_qmat(c_qmat),
        .out_ready(out_ready), .output_enable(oe1), .val(val1), .size_of_bit(size1),
        .flush_bit(flush1), .busy(busy1), .done(done1));

    frame_header_gen #(.VAL_W(64), .QMAT_PER_BEAT(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .start(start), .frame_size(frame_size),
        .horizontal(horizontal), .vertical(vertical), .chroma_format(chroma_format),
        .interlace_mode(interlace_mode), .aspect_ratio_information(aspect_ratio_information),
        .frame_rate_code(frame_rate_code), .color_primaries(color_primaries),
        .transfer_characteristic(transfer_characteristic), .matrix_coefficients(matrix_coefficients),
        .alpha_channel_type(alpha_channel_type), .load_luma_qmat(load_luma_qmat),
        .load_chroma_qmat(load_chroma_qmat), .y_qmat(y_qmat), .c_qmat(c_qmat),
        .out_ready(out_ready), .output_enable(oe8), .val(val8), .size_of_bit(size8),
        .flush_bit(flush8), .busy(busy8), .done(done8));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ent(input logic [511:0] q, input int k);
        logic [511:0] t;
        t = q >> (8 * k);
        return t[7:0];
    endfunction

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.frame_size = $urandom;
        c.h  = 16'($urandom);
        c.v  = 16'($urandom);
        c.cf = 2'($urandom);
        c.im = 2'($urandom);
        c.ar = 4'($urandom);
        c.fr = 4'($urandom);
        c.cp = 8'($urandom);
        c.tc = 8'($urandom);
        c.mc = 8'($urandom);
        c.al = 4'($urandom);
        c.ll = 1'($urandom);
        c.lc = 1'($urandom);
        c.y  = '0;
        c.c  = '0;
        for (int i = 0; i < 16; i++) begin
            c.y = {c.y[479:0], 32'($urandom)};
            c.c = {c.c[479:0], 32'($urandom)};
        end
        return c;
    endfunction

    task automatic drive(input cfg_t c);
        frame_size = c.frame_size;
        horizontal = c.h;
        vertical = c.v;
        chroma_format = c.cf;
        interlace_mode = c.im;
        aspect_ratio_information = c.ar;
        frame_rate_code = c.fr;
        color_primaries = c.cp;
        transfer_characteristic = c.tc;
        matrix_coefficients = c.mc;
        alpha_channel_type = c.al;
        load_luma_qmat = c.ll;
        load_chroma_qmat = c.lc;
        y_qmat = c.y;
        c_qmat = c.c;
    endtask

    // Reference header: field list, then each loaded matrix chopped into n-entry beats.
    task automatic gen_model(input cfg_t c);
        logic [63:0] fv [23];
        logic [63:0] hdr, v;
        logic [511:0] mq;
        beat_t tmp[$];
        hdr = 64'd20 + 64'd64 * 64'(c.ll) + 64'd64 * 64'(c.lc);
        fv = '{64'(c.frame_size), 64'h69637066, hdr, 64'd0, 64'd0, 64'(ENC), 64'(c.h), 64'(c.v),
               64'(c.cf), 64'd0, 64'(c.im), 64'd0, 64'(c.ar), 64'(c.fr), 64'(c.cp), 64'(c.tc),
               64'(c.mc), 64'd4, 64'(c.al), 64'd0, 64'd0, 64'(c.ll), 64'(c.lc)};
        for (int pass = 0; pass < 2; pass++) begin
            automatic int n = (pass == 0) ? 1 : 8;
            tmp.delete();
            for (int i = 0; i < 23; i++) tmp.push_back('{fv[i], 64'(FSZ[i]), 1'b0});
            for (int m = 0; m < 2; m++) begin
                if ((m == 0 && c.ll) || (m == 1 && c.lc)) begin
                    mq = (m == 0) ? c.y : c.c;
                    for (int j = 0; j < 64 / n; j++) begin
                        v = '0;
                        for (int e = 0; e < n; e++) v = (v << 8) | 64'(ent(mq, j * n + e));
                        tmp.push_back('{v, 64'(8 * n), 1'b0});
                    end
                end
            end
            tmp[tmp.size() - 1].f = 1'b1;
            if (pass == 0) exp1 = tmp;
            else exp8 = tmp;
        end
    endtask

    always @(posedge clock) begin
        #1;
        out_ready = bp ? 1'($urandom) : 1'b1;
    end

    // Collect transfers and check that stalled beats hold.
    logic st1 = 1'b0, st8 = 1'b0, sf1, sf8;
    logic [63:0] sv1, ss1, sv8, ss8;
    always @(negedge clock) begin
        if (reset_n) begin
            if (oe1 && out_ready) got1.push_back('{val1, size1, flush1});
            if (oe8 && out_ready) got8.push_back('{val8, size8, flush8});
            if (st1) begin
                chk("stall_oe1", 64'(oe1), 64'd1);
                chk("stall_val1", val1, sv1);
                chk("stall_size1", size1, ss1);
                chk("stall_flush1", 64'(flush1), 64'(sf1));
            end
            if (st8) begin
                chk("stall_oe8", 64'(oe8), 64'd1);
                chk("stall_val8", val8, sv8);
                chk("stall_size8", size8, ss8);
                chk("stall_flush8", 64'(flush8), 64'(sf8));
            end
            st1 = oe1 && !out_ready; sv1 = val1; ss1 = size1; sf1 = flush1;
            st8 = oe8 && !out_ready; sv8 = val8; ss8 = size8; sf8 = flush8;
        end else begin
            st1 = 1'b0;
            st8 = 1'b0;
        end
    end

    task automatic cmp_q(input string nm, input beat_t got[$], input beat_t exp[$], input cfg_t c);
        logic [63:0] bits;
        bits = '0;
        chk({nm, "_count"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            chk($sformatf("%s_val[%0d]", nm, i), got[i].v, exp[i].v);
            chk($sformatf("%s_size[%0d]", nm, i), got[i].s, exp[i].s);
            chk($sformatf("%s_flush[%0d]", nm, i), 64'(got[i].f), 64'(exp[i].f));
        end
        foreach (got[i]) bits += got[i].s;
        chk({nm, "_bits"}, bits, 64'd224 + 64'd512 * (64'(c.ll) + 64'(c.lc)));
    endtask

    task automatic run_header(input cfg_t c, input bit mid);
        int n, d1, d8;
        got1.delete();
        got8.delete();
        gen_model(c);
        @(posedge clock); #2;
        drive(c);
        start = 1'b1;
        @(posedge clock); #2;
        start = 1'b0;
        n = 0; d1 = 0; d8 = 0;
        while (n < 4000) begin
            @(negedge clock);
            n++;
            if (n == 1) begin
                chk("busy_first1", 64'(busy1), 64'd1);
                chk("oe_first8", 64'(oe8), 64'd1);
            end
            if (mid && n == 5) begin drive(rand_cfg()); start = 1'b1; end
            if (mid && n == 7) start = 1'b0;
            if (d1 == 0 && done1) begin
                d1 = n;
                chk("done_busy1", 64'(busy1), 64'd0);
                chk("done_oe1", 64'(oe1), 64'd0);
                if (!bp) chk("latency1", 64'(n), 64'(exp1.size() + 1));
            end
            if (d8 == 0 && done8) begin
                d8 = n;
                chk("done_busy8", 64'(busy8), 64'd0);
                if (!bp) chk("latency8", 64'(n), 64'(exp8.size() + 1));
            end
            if (d1 > 0 && n == d1 + 1) chk("done_pulse1", 64'(done1), 64'd0);
            if (d8 > 0 && n == d8 + 1) chk("done_pulse8", 64'(done8), 64'd0);
            if (d1 > 0 && d8 > 0 && n > d1 + 1 && n > d8 + 1) break;
        end
        if (d1 == 0) chk("timeout1", 64'd0, 64'd1);
        if (d8 == 0) chk("timeout8", 64'd0, 64'd1);
        cmp_q("n1", got1, exp1, c);
        cmp_q("n8", got8, exp8, c);
    endtask

    initial begin
        cfg_t c;
        repeat (3) @(negedge clock);
        chk("rst_oe1", 64'(oe1), 64'd0);
        chk("rst_val1", val1, 64'd0);
        chk("rst_size1", size1, 64'd0);
        chk("rst_flush1", 64'(flush1), 64'd0);
        chk("rst_busy1", 64'(busy1), 64'd0);
        chk("rst_done1", 64'(done1), 64'd0);
        chk("rst_oe8", 64'(oe8), 64'd0);
        chk("rst_busy8", 64'(busy8), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // 1920x1080 with both matrices
        c = rand_cfg(); c.h = 16'd1920; c.v = 16'd1080; c.ll = 1'b1; c.lc = 1'b1;
        run_header(c, 1'b0);
        chk("hd_beats", 64'(got1.size()), 64'd151);
        if (got1.size() >= 8) begin
            chk("hd_hdr_val", got1[2].v, 64'h94);
            chk("hd_hdr_size", got1[2].s, 64'd16);
            chk("hd_width", got1[6].v, 64'h780);
            chk("hd_height", got1[7].v, 64'h438);
        end

        // no matrices
        c = rand_cfg(); c.ll = 1'b0; c.lc = 1'b0;
        run_header(c, 1'b0);
        chk("nomat_beats", 64'(got1.size()), 64'd23);
        if (got1.size() == 23) begin
            chk("nomat_hdr", got1[2].v, 64'h14);
            chk("nomat_f22", got1[21].v, 64'd0);
            chk("nomat_f23", got1[22].v, 64'd0);
            chk("nomat_flush", 64'(got1[22].f), 64'd1);
        end

        // luma only, entries k+1
        c = rand_cfg(); c.ll = 1'b1; c.lc = 1'b0;
        for (int k = 63; k >= 0; k--) c.y = {c.y[503:0], 8'(k + 1)};
        run_header(c, 1'b0);
        chk("luma8_beats", 64'(got8.size()), 64'd31);
        if (got8.size() == 31) begin
            chk("luma8_val", got8[23].v, 64'h0102030405060708);
            chk("luma8_size", got8[23].s, 64'd64);
            chk("luma8_hdr", got8[2].v, 64'h54);
        end

        // backpressure
        bp = 1'b1;
        c = rand_cfg(); c.h = 16'd1920; c.v = 16'd1080; c.ll = 1'b1; c.lc = 1'b1;
        run_header(c, 1'b0);
        for (int t = 0; t < 3; t++) run_header(rand_cfg(), 1'b0);

        // start pulses and input changes mid-header
        run_header(rand_cfg(), 1'b1);
        bp = 1'b0;
        run_header(rand_cfg(), 1'b1);

        // reset while in the luma matrix
        c = rand_cfg(); c.ll = 1'b1; c.lc = 1'b1;
        @(posedge clock); #2;
        drive(c);
        start = 1'b1;
        @(posedge clock); #2;
        start = 1'b0;
        repeat (40) @(negedge clock);
        chk("pre_rst_oe1", 64'(oe1), 64'd1);
        chk("pre_rst_size1", size1, 64'd8);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_oe1", 64'(oe1), 64'd0);
        chk("mid_rst_val1", val1, 64'd0);
        chk("mid_rst_size1", size1, 64'd0);
        chk("mid_rst_flush1", 64'(flush1), 64'd0);
        chk("mid_rst_busy1", 64'(busy1), 64'd0);
        chk("mid_rst_done1", 64'(done1), 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        c = rand_cfg(); c.ll = 1'b1;
        run_header(c, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
